// File: rtl/spi_arb_pkg.sv
// rtl/spi_arb_pkg.sv - shared state encoding and idle pin levels for the SPI flash arbiter
package spi_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN0  = 2'd1,
    OWN1  = 2'd2,
    GUARD = 2'd3
  } arb_state_t;

  localparam logic IDLE_CS_B = 1'b1;
  localparam logic IDLE_SCK  = 1'b1;
  localparam logic IDLE_MOSI = 1'b0;

endpackage

// File: rtl/spi_flash_arbiter.sv
// rtl/spi_flash_arbiter.sv - round-robin owner of the flash SPI pins with guard gap and idle watchdog
module spi_flash_arbiter
  import spi_arb_pkg::*;
#(
  parameter int GUARD_CYCLES   = 4,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic clk,
  input  logic reset,
  input  logic r0_req,
  input  logic r1_req,
  output logic r0_grant,
  output logic r1_grant,
  input  logic r0_cs_b,
  input  logic r1_cs_b,
  input  logic r0_sck,
  input  logic r1_sck,
  input  logic r0_mosi,
  input  logic r1_mosi,
  output logic r0_miso,
  output logic r1_miso,
  output logic spi_cs_b,
  output logic spi_sck,
  output logic spi_mosi,
  input  logic spi_miso,
  output logic busy,
  output logic timeout_err
);

  localparam int GW = $clog2(GUARD_CYCLES + 1);
  localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [GW-1:0] GUARD_LOAD = GW'(GUARD_CYCLES);
  localparam logic [TW-1:0] WD_LAST    = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  arb_state_t      state, state_next;
  logic            last_owner;
  logic [GW-1:0]   guard_cnt;
  logic [TW-1:0]   wd_cnt;
  logic            revoke;
  logic            own_req, own_cs_b;

  always_comb begin
    state_next = state;
    revoke     = 1'b0;
    own_req    = 1'b0;
    own_cs_b   = 1'b1;
    r0_grant   = 1'b0;
    r1_grant   = 1'b0;
    r0_miso    = 1'b0;
    r1_miso    = 1'b0;
    spi_cs_b   = IDLE_CS_B;
    spi_sck    = IDLE_SCK;
    spi_mosi   = IDLE_MOSI;
    busy       = (state != IDLE);

    case (state)
      IDLE: begin
        if (r0_req && r1_req)
          state_next = last_owner ? OWN0 : OWN1;
        else if (r0_req)
          state_next = OWN0;
        else if (r1_req)
          state_next = OWN1;
      end
      OWN0: begin
        r0_grant = 1'b1;
        spi_cs_b = r0_cs_b;
        spi_sck  = r0_sck;
        spi_mosi = r0_mosi;
        r0_miso  = spi_miso;
        own_req  = r0_req;
        own_cs_b = r0_cs_b;
      end
      OWN1: begin
        r1_grant = 1'b1;
        spi_cs_b = r1_cs_b;
        spi_sck  = r1_sck;
        spi_mosi = r1_mosi;
        r1_miso  = spi_miso;
        own_req  = r1_req;
        own_cs_b = r1_cs_b;
      end
      GUARD: begin
        if (guard_cnt <= GW'(1))
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    // Ownership ends only with cs_b high: either a clean release or an idle-hold revoke.
    if (state == OWN0 || state == OWN1) begin
      if (!own_req && own_cs_b) begin
        state_next = GUARD;
      end else if (TIMEOUT_CYCLES > 0 && own_req && own_cs_b && wd_cnt == WD_LAST) begin
        state_next = GUARD;
        revoke     = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      last_owner  <= 1'b1;
      guard_cnt   <= '0;
      wd_cnt      <= '0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_next;
      timeout_err <= revoke;

      if (state_next == GUARD && state != GUARD)
        guard_cnt <= GUARD_LOAD;
      else if (state == GUARD && guard_cnt != '0)
        guard_cnt <= guard_cnt - 1'b1;

      if (state == IDLE) begin
        wd_cnt <= '0;
        if (state_next == OWN0)
          last_owner <= 1'b0;
        else if (state_next == OWN1)
          last_owner <= 1'b1;
      end else if (!own_cs_b) begin
        wd_cnt <= '0;
      end else if (TIMEOUT_CYCLES > 0 && own_req && wd_cnt != WD_LAST) begin
        wd_cnt <= wd_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_spi_flash_arbiter.sv
// tb/tb_spi_flash_arbiter.sv - scoreboard bench for the SPI flash arbiter
module tb_spi_flash_arbiter;

  localparam int GUARD = 4;
  localparam int TMO   = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic r0_req = 1'b0, r1_req = 1'b0;
  logic r0_cs_b = 1'b1, r1_cs_b = 1'b1;
  logic r0_sck = 1'b1, r1_sck = 1'b1;
  logic r0_mosi = 1'b0, r1_mosi = 1'b0;
  logic spi_miso = 1'b0;
  logic r0_grant, r1_grant, r0_miso, r1_miso;
  logic spi_cs_b, spi_sck, spi_mosi, busy, timeout_err;

  logic n_r1_req = 1'b0;
  logic n_low = 1'b0, n_high = 1'b1;
  logic n_r0_grant, n_r1_grant, n_r0_miso, n_r1_miso;
  logic n_cs_b, n_sck, n_mosi, n_busy, n_terr;

  typedef struct packed {
    logic cs_b;
    logic sck;
    logic mosi;
    logic miso0;
    logic miso1;
  } pins_t;

  pins_t sb[$];
  pins_t mon_e;
  int    own = -1;
  int    checks = 0;
  int    errors = 0;

  always #5 clk = ~clk;

  spi_flash_arbiter #(.GUARD_CYCLES(GUARD), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(rst),
    .r0_req(r0_req), .r1_req(r1_req),
    .r0_grant(r0_grant), .r1_grant(r1_grant),
    .r0_cs_b(r0_cs_b), .r1_cs_b(r1_cs_b),
    .r0_sck(r0_sck), .r1_sck(r1_sck),
    .r0_mosi(r0_mosi), .r1_mosi(r1_mosi),
    .r0_miso(r0_miso), .r1_miso(r1_miso),
    .spi_cs_b(spi_cs_b), .spi_sck(spi_sck), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .busy(busy), .timeout_err(timeout_err)
  );

  spi_flash_arbiter #(.GUARD_CYCLES(GUARD), .TIMEOUT_CYCLES(0)) u_nowd (
    .clk(clk), .reset(rst),
    .r0_req(n_low), .r1_req(n_r1_req),
    .r0_grant(n_r0_grant), .r1_grant(n_r1_grant),
    .r0_cs_b(n_high), .r1_cs_b(n_high),
    .r0_sck(n_high), .r1_sck(n_high),
    .r0_mosi(n_low), .r1_mosi(n_low),
    .r0_miso(n_r0_miso), .r1_miso(n_r1_miso),
    .spi_cs_b(n_cs_b), .spi_sck(n_sck), .spi_mosi(n_mosi),
    .spi_miso(n_low), .busy(n_busy), .timeout_err(n_terr)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one requester's pins for this cycle and queue what the flash side must show.
  task automatic drive_pins(input int who, input logic cs, input logic sck, input logic mosi,
                            input logic miso);
    pins_t e;
    if (who == 0) begin
      r0_cs_b = cs; r0_sck = sck; r0_mosi = mosi;
    end else begin
      r1_cs_b = cs; r1_sck = sck; r1_mosi = mosi;
    end
    spi_miso = miso;
    e = '{cs_b: 1'b1, sck: 1'b1, mosi: 1'b0, miso0: 1'b0, miso1: 1'b0};
    if (own == 0) begin
      e.cs_b = r0_cs_b; e.sck = r0_sck; e.mosi = r0_mosi; e.miso0 = miso;
    end else if (own == 1) begin
      e.cs_b = r1_cs_b; e.sck = r1_sck; e.mosi = r1_mosi; e.miso1 = miso;
    end
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      check("spi_cs_b", spi_cs_b, mon_e.cs_b);
      check("spi_sck", spi_sck, mon_e.sck);
      check("spi_mosi", spi_mosi, mon_e.mosi);
      check("r0_miso", r0_miso, mon_e.miso0);
      check("r1_miso", r1_miso, mon_e.miso1);
    end
  end

  task automatic wait_idle();
    bit done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (!busy) done = 1'b1;
      else tick();
    end
    check("wait_idle", done, 1);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    r0_req = 1'b0; r1_req = 1'b0;
    r0_cs_b = 1'b1; r1_cs_b = 1'b1; r0_sck = 1'b1; r1_sck = 1'b1;
    own = -1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1);
  end

  initial begin
    int gb, hold, gap, gcnt, tcnt, tidx, regrant, ng, nt;
    bit found, revoked;

    #2;
    check("rst_grant0", r0_grant, 0);
    check("rst_grant1", r1_grant, 0);
    check("rst_cs_b", spi_cs_b, 1);
    check("rst_sck", spi_sck, 1);
    check("rst_mosi", spi_mosi, 0);
    check("rst_busy", busy, 0);
    check("rst_terr", timeout_err, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // single requester, full byte, then guard gap
    tick();
    r0_req = 1'b1;
    @(negedge clk);
    check("t1_grant_early", r0_grant, 0);
    tick();
    own = 0;
    drive_pins(0, 1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    check("t1_grant", r0_grant, 1);
    check("t1_busy", busy, 1);
    for (int i = 0; i < 16; i++) begin
      tick();
      drive_pins(0, 1'b0, i[0], 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    tick();
    r0_req = 1'b0;
    drive_pins(0, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    own = -1;
    gb = 0;
    for (int i = 0; i < 8; i++) begin
      drive_pins(0, 1'b0, i[0], 1'b1, 1'b1);
      @(negedge clk);
      if (busy) gb++;
      check("t1_guard_grant", r0_grant, 0);
      tick();
    end
    check("t1_guard_len", gb, GUARD);
    r0_cs_b = 1'b1; r0_sck = 1'b1; r0_mosi = 1'b0;
    @(negedge clk);
    check("t1_busy_end", busy, 0);

    // contention and round-robin
    apply_reset();
    tick();
    r0_req = 1'b1; r1_req = 1'b1;
    tick();
    @(negedge clk);
    check("t2_first_g0", r0_grant, 1);
    check("t2_first_g1", r1_grant, 0);
    tick();
    r0_req = 1'b0; r1_req = 1'b0;
    tick();
    wait_idle();
    tick();
    r0_req = 1'b1; r1_req = 1'b1;
    tick();
    @(negedge clk);
    check("t2_rr_g1", r1_grant, 1);
    check("t2_rr_g0", r0_grant, 0);
    tick();
    r0_req = 1'b0; r1_req = 1'b0;
    wait_idle();

    // req drops mid-transaction: ownership held until cs_b rises
    tick();
    r0_req = 1'b1;
    tick();
    @(negedge clk);
    check("t3_g0", r0_grant, 1);
    tick();
    r0_cs_b = 1'b0; r0_req = 1'b0; r1_req = 1'b1;
    hold = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (r0_grant && !r1_grant) hold++;
      tick();
    end
    check("t3_hold", hold, 10);
    r0_cs_b = 1'b1;
    @(negedge clk);
    check("t3_still_owner", r0_grant, 1);
    gap = 0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      @(negedge clk);
      if (r1_grant) found = 1'b1;
      else gap++;
    end
    check("t3_r1_granted", found, 1);
    check("t3_gap", gap, GUARD + 1);

    // miso isolation while r1 owns; r0 pins wiggle and must be ignored
    own = 1;
    for (int i = 0; i < 8; i++) begin
      tick();
      r0_sck = i[0]; r0_cs_b = i[1]; r0_mosi = ~i[0];
      drive_pins(1, 1'b0, i[0], 1'($urandom_range(0, 1)), i[0] ^ i[2]);
    end
    tick();
    r1_req = 1'b0;
    r0_sck = 1'b1; r0_cs_b = 1'b1; r0_mosi = 1'b0;
    drive_pins(1, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    own = -1;
    wait_idle();

    // watchdog revoke with cs_b held high, then normal re-arbitration
    tick();
    r1_req = 1'b1;
    tick();
    gcnt = 0; tcnt = 0; tidx = -1; regrant = -1; revoked = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (timeout_err) begin
        tcnt++;
        tidx = i;
        revoked = 1'b1;
        check("t4_revoke_grant", r1_grant, 0);
        check("t4_revoke_busy", busy, 1);
      end
      if (r1_grant && !revoked) gcnt++;
      if (r1_grant && revoked && regrant < 0) regrant = i;
      tick();
    end
    check("t4_grant_len", gcnt, TMO);
    check("t4_terr_pulses", tcnt, 1);
    check("t4_terr_cycle", tidx, TMO);
    check("t4_regrant_cycle", regrant, TMO + GUARD + 1);
    r1_req = 1'b0;
    wait_idle();

    // watchdog disabled: idle hold is never revoked
    tick();
    n_r1_req = 1'b1;
    tick();
    tick();
    ng = 0; nt = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (n_r1_grant) ng++;
      if (n_terr) nt++;
      tick();
    end
    check("t4_nowd_grant", ng, 100);
    check("t4_nowd_terr", nt, 0);
    n_r1_req = 1'b0;

    // asynchronous reset mid-byte
    tick();
    r0_req = 1'b1;
    tick();
    own = 0;
    for (int i = 0; i < 3; i++) begin
      drive_pins(0, 1'b0, i[0], 1'b1, 1'b1);
      tick();
    end
    drive_pins(0, 1'b0, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("t5_async_cs_b", spi_cs_b, 1);
    check("t5_async_sck", spi_sck, 1);
    check("t5_async_mosi", spi_mosi, 0);
    check("t5_async_grant", r0_grant, 0);
    check("t5_async_miso", r0_miso, 0);
    check("t5_async_busy", busy, 0);
    own = -1;
    r0_cs_b = 1'b1; r0_sck = 1'b1; r0_mosi = 1'b0;
    r1_req = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tick();
    @(negedge clk);
    check("t5_post_g0", r0_grant, 1);
    check("t5_post_g1", r1_grant, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
